io_edge_monitor: RTL and testbench
==================================

IO_EDGE_MONITOR -- requirements
Module: io_edge_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of the monitored IO bus.
REQ-002 SHALL have parameter DEPTH, default 16: event FIFO entries, power of two, 2..256.
REQ-003 SHALL have parameter TS_WIDTH, default 32: timestamp counter width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchronizer flops, 0..3; 0 means the input is used directly.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port enable  input  1  capture enable.
REQ-008 SHALL have port in  input  WIDTH  monitored IO bus.
REQ-009 SHALL have port edge_mask  input  WIDTH  per-bit capture enable.
REQ-010 SHALL have port evt_valid  output  1  event available.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-012 SHALL have port evt_value  output  WIDTH  bus value after the change.
REQ-013 SHALL have port evt_timestamp  output  TS_WIDTH  counter value at capture.
REQ-014 SHALL have port evt_level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky event-dropped flag.
REQ-016 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-017 SHALL define the sampled value s as in after SYNC_STAGES flops, and p as s registered one cycle.
REQ-018 SHALL run the FSM PRIME -> IDLE/ACTIVE: PRIME lasts exactly one cycle after reset, loads p, and emits no event; it then goes to ACTIVE if enable=1, otherwise IDLE.
REQ-019 SHALL move IDLE<->ACTIVE on the enable level, with the new state taking effect the cycle after the enable change.
REQ-020 SHALL keep p tracking s in every state, so that re-enabling never produces an event for changes that occurred while IDLE.
REQ-021 SHALL detect a change in ACTIVE when ((s ^ p) & edge_mask) != 0, and push {s, ts} into the FIFO on that cycle.
REQ-022 SHALL capture all bits changing on the same cycle as one event.
REQ-023 SHALL make the timestamp ts free-running from 0 after reset, increment every cycle in every state, and wrap from 2^TS_WIDTH-1 to 0 with no flag.
REQ-024 SHALL assert evt_valid one cycle after the push into an empty FIFO (latency 1 from the detecting cycle).
REQ-025 SHALL follow valid/ready rules: the head pops when evt_valid && evt_ready; evt_value and evt_timestamp are held stable while evt_valid=1 and evt_ready=0; evt_valid never drops without a pop.
REQ-026 SHALL, when a push occurs with level=DEPTH and no pop that cycle, drop the event and set overflow.
REQ-027 SHALL, when a push occurs with level=DEPTH and a pop that cycle, accept the push with level unchanged and leave overflow unchanged.
REQ-028 SHALL update evt_level in the cycle after each push or pop, and leave it unchanged on a simultaneous push and pop.
REQ-029 SHALL clear overflow on overflow_clr, with a set on the same cycle taking priority.
REQ-030 SHALL continue draining the FIFO in IDLE.

Reset
REQ-031 SHALL, on rst, set the following: evt_valid=0, evt_level=0, overflow=0, evt_value=0, evt_timestamp=0, ts=0, synchronizer and p=0, FIFO pointers=0, state=PRIME.
REQ-032 SHALL discard FIFO contents on a mid-operation reset; an event detected on the reset cycle SHALL NOT be stored.

Structure
REQ-033 SHALL take the FSM state enum and the event struct type {value, timestamp} from shared package io_vip_pkg.
REQ-034 SHALL implement the FIFO as sub-module io_event_fifo (synchronous, first-word-fall-through, occupancy output).

Verification
REQ-035 SHALL cover: WIDTH=4, SYNC_STAGES=0, in 0x0 -> 0x5 at ts=10 -> one event with value 0x5 and ts 10, evt_valid high at ts 11.
REQ-036 SHALL cover: edge_mask=0x1, in 0x0 -> 0x2 -> 0x3 -> exactly one event, value 0x3.
REQ-037 SHALL cover: evt_ready=0, DEPTH=4, six toggles -> level 4, overflow=1; drain -> the first four values in order.
REQ-038 SHALL cover: full FIFO, push and pop on the same cycle -> level stays 4, overflow stays 0.
REQ-039 SHALL cover: enable=0, in toggles, then enable=1 with in static -> no event; overflow_clr and overflow set on the same cycle -> overflow=1.
REQ-040 SHALL cover: TS_WIDTH=4, change at cycle 17 after reset -> ts 1; rst mid-stream -> evt_valid=0 and level 0 the next cycle.

Source files
------------

// File: rtl/io_vip_pkg.sv
// io_vip_pkg: shared monitor state and event types for the io edge monitor.
package io_vip_pkg;
    localparam int EVT_VALUE_MAX = 64;
    localparam int EVT_TS_MAX = 64;
    typedef enum logic [1:0] {ST_PRIME, ST_IDLE, ST_ACTIVE} mon_state_e;
    typedef struct packed {
        logic [EVT_VALUE_MAX-1:0] value;
        logic [EVT_TS_MAX-1:0]    timestamp;
    } evt_t;
endpackage

// File: rtl/io_event_fifo.sv
// io_event_fifo: synchronous first-word-fall-through event FIFO with occupancy and drop report.
module io_event_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    output logic                     valid,
    input  logic                     ready,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, wr, full;
    assign valid = level != '0;
    // Head is forced to zero while empty so the outputs read 0 out of reset.
    assign rdata = valid ? mem[rd_ptr] : '0;
    always_comb begin
        full = level == FULL_LEVEL;
        pop  = valid && ready;
        wr   = push && (!full || pop);
        drop = push && full && !pop;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/io_edge_monitor.sv
// io_edge_monitor: timestamps masked changes on an IO bus and queues them as events.
module io_edge_monitor
    import io_vip_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       in,
    input  logic [WIDTH-1:0]       edge_mask,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [WIDTH-1:0]       evt_value,
    output logic [TS_WIDTH-1:0]    evt_timestamp,
    output logic [$clog2(DEPTH):0] evt_level,
    output logic                   overflow,
    input  logic                   overflow_clr
);
    logic [WIDTH-1:0]          s, p;
    logic [TS_WIDTH-1:0]       ts;
    logic [WIDTH+TS_WIDTH-1:0] rdata;
    mon_state_e                state_q, state_d;
    logic                      push, drop;
    evt_t                      head, unused_head;
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [WIDTH-1:0] sq [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    sq <= '{default: '0};
                end else begin
                    sq[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) sq[i] <= sq[i-1];
                end
            end
            assign s = sq[SYNC_STAGES-1];
        end
    endgenerate
    // p follows s in every state so re-enabling never reports stale changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            p        <= '0;
            ts       <= '0;
            state_q  <= ST_PRIME;
            overflow <= 1'b0;
        end else begin
            p        <= s;
            ts       <= ts + TS_WIDTH'(1);
            state_q  <= state_d;
            overflow <= drop || (overflow && !overflow_clr);
        end
    end
    always_comb begin
        state_d = enable ? ST_ACTIVE : ST_IDLE;
        push    = (state_q == ST_ACTIVE) && (((s ^ p) & edge_mask) != '0);
    end
    io_event_fifo #(.DW(WIDTH + TS_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({s, ts}),
        .valid (evt_valid),
        .ready (evt_ready),
        .rdata (rdata),
        .level (evt_level),
        .drop  (drop)
    );
    always_comb begin
        head = '0;
        head.value[WIDTH-1:0]        = rdata[TS_WIDTH +: WIDTH];
        head.timestamp[TS_WIDTH-1:0] = rdata[TS_WIDTH-1:0];
    end
    assign unused_head   = head;
    assign evt_value     = head.value[WIDTH-1:0];
    assign evt_timestamp = head.timestamp[TS_WIDTH-1:0];
endmodule

// File: tb/tb_io_edge_monitor.sv
// tb_io_edge_monitor: directed scoreboard bench for io_edge_monitor (WIDTH=4, DEPTH=4, TS_WIDTH=4, no sync).
module tb_io_edge_monitor;
    logic       clk = 1'b0;
    logic       rst, enable, evt_ready, overflow_clr;
    logic [3:0] in, edge_mask;
    logic       evt_valid, overflow;
    logic [3:0] evt_value, evt_timestamp;
    logic [2:0] evt_level;
    logic [3:0] tb_ts;
    int         tests = 0;
    int         fails = 0;
    typedef struct {
        logic [3:0] v;
        logic [3:0] t;
    } exp_t;
    exp_t q[$];

    io_edge_monitor #(.WIDTH(4), .DEPTH(4), .TS_WIDTH(4), .SYNC_STAGES(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in            (in),
        .edge_mask     (edge_mask),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_value     (evt_value),
        .evt_timestamp (evt_timestamp),
        .evt_level     (evt_level),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    // Reference timestamp: zero on reset, +1 every cycle, 4-bit wrap.
    always @(posedge clk) tb_ts <= rst ? 4'd0 : tb_ts + 4'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [3:0] v, input logic [3:0] t);
        exp_t e;
        e.v = v;
        e.t = t;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (q.size() == 0 && evt_valid === 1'b0) done = 1;
            else step();
        end
        evt_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, done}, 32'd1);
        check({tag, "_level0"}, {29'd0, evt_level}, 32'd0);
    endtask

    // Scoreboard: each handshake seen mid-cycle pops the oldest expectation.
    always @(negedge clk) begin
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("sb_value", {28'd0, evt_value}, {28'd0, e.v});
                check("sb_ts", {28'd0, evt_timestamp}, {28'd0, e.t});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; in = 4'h0; edge_mask = 4'hF;
        evt_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_level", {29'd0, evt_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_value", {28'd0, evt_value}, 32'd0);
        check("rst_ts", {28'd0, evt_timestamp}, 32'd0);
        rst = 1'b0;

        // Single event at ts 10, valid one cycle later.
        for (int i = 0; i < 20 && tb_ts != 4'd10; i++) step();
        check("at_ts10", {28'd0, tb_ts}, 32'd10);
        in = 4'h5;
        expect_evt(4'h5, 4'd10);
        check("lat_not_yet", {31'd0, evt_valid}, 32'd0);
        step();
        check("lat_valid", {31'd0, evt_valid}, 32'd1);
        check("lat_value", {28'd0, evt_value}, 32'h5);
        check("lat_ts", {28'd0, evt_timestamp}, 32'd10);
        drain("single");

        // Masked bits never trigger; unmasked bit change captures full value.
        in = 4'h0;
        expect_evt(4'h0, tb_ts);
        step();
        drain("mask_prep");
        edge_mask = 4'h1;
        in = 4'h2;
        step();
        in = 4'h3;
        expect_evt(4'h3, tb_ts);
        step(); step();
        check("mask_level", {29'd0, evt_level}, 32'd1);
        drain("mask");
        edge_mask = 4'hF;

        // Six changes into a 4-deep FIFO with no consumer.
        for (int i = 0; i < 6; i++) begin
            in = 4'(8 + i);
            if (i < 4) expect_evt(4'(8 + i), tb_ts);
            step();
        end
        check("ovf_level", {29'd0, evt_level}, 32'd4);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        drain("ovf");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            in = 4'(i);
            expect_evt(4'(i), tb_ts);
            step();
        end
        check("full_level", {29'd0, evt_level}, 32'd4);
        in = 4'h4;
        expect_evt(4'h4, tb_ts);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("pp_level", {29'd0, evt_level}, 32'd4);
        check("pp_overflow", {31'd0, overflow}, 32'd0);
        drain("pp");

        // Changes while disabled are forgotten on re-enable.
        enable = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            in = 4'(6 + i);
            step();
        end
        enable = 1'b1;
        step(); step(); step();
        check("idle_level", {29'd0, evt_level}, 32'd0);
        check("idle_valid", {31'd0, evt_valid}, 32'd0);
        in = 4'h9;
        expect_evt(4'h9, tb_ts);
        step();
        check("reen_level", {29'd0, evt_level}, 32'd1);
        enable = 1'b0;
        step();
        drain("idle_drain");

        // Overflow set beats a same-cycle clear.
        enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            in = 4'(10 + i);
            expect_evt(4'(10 + i), tb_ts);
            step();
        end
        in = 4'hE;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("setclr_ovf", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        drain("setclr");

        // Timestamp wrap: change 17 cycles after reset carries ts 1.
        in = 4'h7;
        rst = 1'b1;
        step();
        q.delete();
        rst = 1'b0;
        for (int c = 0; c < 17; c++) step();
        check("prime_no_event", {29'd0, evt_level}, 32'd0);
        in = 4'h8;
        expect_evt(4'h8, 4'd1);
        step();
        check("wrap_ts", {28'd0, evt_timestamp}, 32'd1);
        check("wrap_valid", {31'd0, evt_valid}, 32'd1);
        drain("wrap");

        // Reset in mid-stream discards contents and the reset-cycle event.
        in = 4'h9;
        step();
        in = 4'hA;
        rst = 1'b1;
        step();
        check("mrst_valid", {31'd0, evt_valid}, 32'd0);
        check("mrst_level", {29'd0, evt_level}, 32'd0);
        q.delete();
        rst = 1'b0;
        step(); step(); step();
        check("mrst_still_empty", {29'd0, evt_level}, 32'd0);
        check("mrst_overflow", {31'd0, overflow}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
